acc_arbiter: RTL and testbench
==============================

# acc_arbiter

Round-robin scheduler that shares one 8-bit accumulator datapath (ripple adder plus register) among N requesters. Each granted requester streams a burst of operands. The block clears the accumulator at burst start and sums every accepted beat. At the final beat it publishes the sum, carry-overflow flag, beat count and requester ID for one cycle. It sits between requesting engines and the accumulate datapath and owns the accumulator's clear, enable and ownership.

## Interface
- N_REQ, 4, number of requesters; legal 2..8
- WIDTH, 8, operand and accumulator width
- IDW, clog2(N_REQ), requester ID width (derived)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- req  in  N_REQ  per-requester request; with grant, marks a valid beat
- data  in  N_REQ*WIDTH  per-requester operand; requester i on bits [i*WIDTH +: WIDTH]
- last  in  N_REQ  per-requester final-beat marker, sampled only on an accepted beat
- gnt  out  N_REQ  one-hot grant; doubles as ready for the owner
- busy  out  1  high in ACCUM and DONE
- res_valid  out  1  one-cycle result strobe
- res_data  out  WIDTH  burst sum modulo 2^WIDTH
- res_id  out  IDW  requester that produced the result
- res_ovf  out  1  sticky carry-out of any beat in the burst
- res_beats  out  8  accepted beat count, saturating at 255

## Operation
- FSM states are IDLE, ACCUM and DONE.
- **IDLE:** gnt=0.
  - If any req bit is high, select the winner by round-robin and load the owner register.
  - Also clear acc, ovf and cnt, then go to ACCUM.
  - Otherwise stay in IDLE.
- **Round-robin:** pointer ptr holds the last served ID.
  - Priority search starts at (ptr+1) mod N_REQ and wraps around.
  - ptr updates to the owner on entry to DONE.
- **ACCUM:** gnt[owner]=1; other req bits are ignored and may stay high.
  - An accepted beat is a cycle with req[owner]=1.
  - On an accepted beat: acc <= acc + data[owner] (WIDTH-bit sum), ovf <= ovf | carry-out, cnt <= sat(cnt+1).
  - If last[owner]=1 on the accepted beat, go to DONE.
  - If req[owner]=0, the beat is a stall: nothing changes, the grant is held, and there is no timeout.
- **DONE:** gnt=0 and res_valid=1 for exactly one cycle.
  - res_data, res_ovf, res_beats and res_id are registered from acc, ovf, cnt and owner.
  - The next state is IDLE.
- res_* hold their last values between strobes.
- last on a non-accepted beat has no effect.
- A one-beat burst (last on the first beat) gives res_data = data and res_beats = 1.

## Timing
- **Reset values:** gnt=0, busy=0, res_valid=0, res_data=0, res_id=0, res_ovf=0, res_beats=0, acc=0, ptr=N_REQ-1, state=IDLE.
- After reset, requester 0 has top priority.
- **Grant latency:** req is sampled high in IDLE at edge t; gnt is high from cycle t+1.
- The first beat can be accepted in the first cycle gnt is high.
- **Result latency:** last is accepted at edge k; res_valid is high in cycle k+1.
- **Back-to-back:** the earliest next grant is cycle k+3, so the minimum inter-burst gap is 2 idle grant cycles.
- **Throughput:** 1 beat per cycle while req[owner] stays high.
- **Reset mid-burst:** the burst is aborted with no res_valid. All outputs and ptr return to their reset values on the next edge.
- Simultaneous requests in IDLE: exactly one grant, chosen by round-robin order.
- gnt is never asserted to more than one requester, and never asserted in IDLE or DONE.

## Test plan
- **Single burst.** req0 sends beats 10, 20, 30 with last on 30. Expect gnt=0001 one cycle after req; then res_valid pulse with res_data=60, res_id=0, res_beats=3, res_ovf=0.
- **Overflow.** req1 sends 200 then 100 with last. Expect res_data=44, res_ovf=1, res_beats=2, res_id=1.
- **Round-robin fairness.** All 4 req held high, each sending 1-beat bursts of data equal to its ID+1. Expect res_id sequence 0,1,2,3,0 and res_data 1,2,3,4,1. Expect a 2-cycle gap between the last beat and the next grant.
- **Stall.** req2 sends 5, drops req for 3 cycles, then sends 7 with last. Expect gnt held throughout, res_data=12 and res_beats=2.
- **Reset mid-burst.** req3 sends 2 beats and rst is pulsed before last. Expect no res_valid, all outputs 0 on the next cycle. A subsequent simultaneous req0 and req3 grants requester 0 first.
- **Saturation.** 300 beats of 1 with last on the final beat. Expect res_beats=255, res_data=44 and res_ovf=1.

Source files
------------

// File: rtl/acc_arbiter.sv
// acc_arbiter
//   Round-robin owner of a shared WIDTH-bit accumulator. A granted requester
//   streams a burst of operands. The accumulator is cleared at burst start and
//   sums every accepted beat. On the final beat the sum, a sticky carry flag,
//   a saturating beat count and the owner ID are published for one cycle.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   req        [N_REQ]        per-requester request; with gnt marks a valid beat
//   data       [N_REQ*WIDTH]  operand of requester i at [i*WIDTH +: WIDTH]
//   last       [N_REQ]        final-beat marker, only meaningful on an accepted beat
//   gnt        [N_REQ]        one-hot grant, doubles as ready for the owner
//   busy                      high while a burst is in progress or completing
//   res_valid                 one-cycle result strobe
//   res_data   [WIDTH]        burst sum modulo 2^WIDTH
//   res_id     [IDW]          requester that produced the result
//   res_ovf                   carry-out seen on any beat of the burst
//   res_beats  [8]            accepted beat count, saturating at 255
module acc_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  localparam int IDW  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] data,
  input  logic [N_REQ-1:0]       last,
  output logic [N_REQ-1:0]       gnt,
  output logic                   busy,
  output logic                   res_valid,
  output logic [WIDTH-1:0]       res_data,
  output logic [IDW-1:0]         res_id,
  output logic                   res_ovf,
  output logic [7:0]             res_beats
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state, state_nxt;
  logic [IDW-1:0]   owner;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   win;
  logic [IDW-1:0]   idx;
  logic [WIDTH-1:0] acc;
  logic             ovf;
  logic [7:0]       cnt;
  logic [WIDTH-1:0] op [N_REQ];
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             beat_ok;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  for (genvar i = 0; i < N_REQ; i++) begin : g_op
    assign op[i] = data[i*WIDTH +: WIDTH];
  end

  // Round-robin search starting one past the last served requester.
  always_comb begin
    win = ptr;
    idx = ptr;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = IDW'((int'(ptr) + i) % N_REQ);
      // Descending order so the nearest requester after ptr is written last.
      if (req[idx]) win = idx;
    end
  end

  assign beat_ok        = (state == ACCUM) && req[owner];
  assign {carry, sum}   = {1'b0, acc} + {1'b0, op[owner]};

  // Control: state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    gnt       = '0;
    busy      = 1'b0;
    res_valid = 1'b0;
    case (state)
      IDLE:  if (|req) state_nxt = ACCUM;
      ACCUM: begin
        gnt[owner] = 1'b1;
        busy       = 1'b1;
        if (req[owner] && last[owner]) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Accumulate and publish: the result registers load on the final beat so
  // they are valid during the DONE strobe cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner     <= '0;
      ptr       <= IDW'(N_REQ - 1);
      acc       <= '0;
      ovf       <= 1'b0;
      cnt       <= '0;
      res_data  <= '0;
      res_id    <= '0;
      res_ovf   <= 1'b0;
      res_beats <= '0;
    end else if (state == IDLE) begin
      if (|req) begin
        owner <= win;
        acc   <= '0;
        ovf   <= 1'b0;
        cnt   <= '0;
      end
    end else if (beat_ok) begin
      acc <= sum;
      ovf <= ovf | carry;
      cnt <= sat_inc(cnt);
      if (last[owner]) begin
        res_data  <= sum;
        res_ovf   <= ovf | carry;
        res_beats <= sat_inc(cnt);
        res_id    <= owner;
        ptr       <= owner;
      end
    end
  end

endmodule

// File: tb/tb_acc_arbiter.sv
// tb_acc_arbiter
//   Directed bench for acc_arbiter (N_REQ=4, WIDTH=8). Stimulus pushes the
//   hand-computed result of each burst into a queue; a monitor pops and
//   compares whenever res_valid is seen.
module tb_acc_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [N*W-1:0] data;
  logic [N-1:0] last;
  logic [N-1:0] gnt;
  logic         busy;
  logic         res_valid;
  logic [W-1:0] res_data;
  logic [1:0]   res_id;
  logic         res_ovf;
  logic [7:0]   res_beats;

  acc_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req(req), .data(data), .last(last),
    .gnt(gnt), .busy(busy), .res_valid(res_valid), .res_data(res_data),
    .res_id(res_id), .res_ovf(res_ovf), .res_beats(res_beats)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int sum;
    int ovf;
    int beats;
  } exp_t;

  exp_t       expq [$];
  logic [7:0] bv [$];
  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int id, input int sum, input int ovf, input int beats);
    exp_t e;
    e.id = id; e.sum = sum; e.ovf = ovf; e.beats = beats;
    expq.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", int'(busy), 0);
  endtask

  // Drives the burst held in bv for requester id. Before beat stall_at the
  // request is dropped for stall_len cycles with last raised, which must
  // have no effect.
  task automatic run_burst(input int id, input int stall_at, input int stall_len);
    int n = bv.size();
    wait_idle();
    req[id] = 1'b1;
    data[id*W +: W] = bv[0];
    last[id] = (n == 1);
    chk("gnt_in_idle", int'(gnt), 0);
    @(negedge clk);
    chk("gnt_latency", int'(gnt), 1 << id);
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          req[id]  = 1'b0;
          last[id] = 1'b1;
          @(negedge clk);
          chk("gnt_held_stall", int'(gnt), 1 << id);
        end
      end
      req[id] = 1'b1;
      data[id*W +: W] = bv[i];
      last[id] = (i == n - 1);
      @(negedge clk);
    end
    chk("res_latency", int'(res_valid), 1);
    chk("gnt_off_done", int'(gnt), 0);
    req[id]  = 1'b0;
    last[id] = 1'b0;
  endtask

  initial begin
    int gcnt;
    int prev_g;
    int n;

    rst  = 1'b1;
    req  = '0;
    data = '0;
    last = '0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_res_data", int'(res_data), 0);
    chk("rst_res_id", int'(res_id), 0);
    chk("rst_res_ovf", int'(res_ovf), 0);
    chk("rst_res_beats", int'(res_beats), 0);
    rst = 1'b0;

    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (!rst) begin
          chk("gnt_onehot", int'($onehot0(gnt)), 1);
          if (gnt != 0) chk("gnt_implies_busy", int'(busy), 1);
          if (res_valid) begin
            if (expq.size() == 0) begin
              chk("unexpected_res_valid", 1, 0);
            end else begin
              e = expq.pop_front();
              chk("res_id", int'(res_id), e.id);
              chk("res_data", int'(res_data), e.sum);
              chk("res_ovf", int'(res_ovf), e.ovf);
              chk("res_beats", int'(res_beats), e.beats);
            end
          end
        end
      end
    join_none

    // Round-robin fairness straight after reset: requester 0 first.
    wait_idle();
    for (int i = 0; i < 5; i++) push_exp(i % N, (i % N) + 1, 0, 1);
    data = {8'd4, 8'd3, 8'd2, 8'd1};
    last = 4'hF;
    req  = 4'hF;
    gcnt = 0;
    prev_g = 0;
    n = 0;
    while (gcnt < 5 && n < 40) begin
      @(negedge clk);
      n++;
      if (gnt != 0) begin
        chk("rr_order", int'(gnt), 1 << (gcnt % N));
        if (gcnt > 0) chk("rr_gap", cyc - prev_g, 3);
        prev_g = cyc;
        gcnt++;
      end
    end
    chk("rr_grant_count", gcnt, 5);
    @(negedge clk);
    req  = '0;
    last = '0;

    bv = '{8'd10, 8'd20, 8'd30};
    push_exp(0, 60, 0, 3);
    run_burst(0, -1, 0);

    bv = '{8'd200, 8'd100};
    push_exp(1, 44, 1, 2);
    run_burst(1, -1, 0);

    bv = '{8'd5, 8'd7};
    push_exp(2, 12, 0, 2);
    run_burst(2, 1, 3);

    bv.delete();
    for (int i = 0; i < 300; i++) bv.push_back(8'd1);
    push_exp(0, 44, 1, 255);
    run_burst(0, -1, 0);

    // Reset mid-burst from requester 3, then a simultaneous 0/3 request.
    wait_idle();
    req[3] = 1'b1;
    data[3*W +: W] = 8'd2;
    last[3] = 1'b0;
    @(negedge clk);
    chk("gnt3", int'(gnt), 4'b1000);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_gnt", int'(gnt), 0);
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_res_valid", int'(res_valid), 0);
    chk("mrst_res_data", int'(res_data), 0);
    chk("mrst_res_id", int'(res_id), 0);
    chk("mrst_res_ovf", int'(res_ovf), 0);
    chk("mrst_res_beats", int'(res_beats), 0);
    push_exp(0, 9, 0, 1);
    push_exp(3, 8, 0, 1);
    data[0*W +: W] = 8'd9;
    data[3*W +: W] = 8'd8;
    req  = 4'b1001;
    last = 4'b1001;
    @(negedge clk);
    chk("rr_after_reset", int'(gnt), 4'b0001);
    n = 0;
    while (gnt != 4'b1000 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("second_grant", int'(gnt), 4'b1000);
    @(negedge clk);
    req  = '0;
    last = '0;

    n = 0;
    while (expq.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("queue_drained", expq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
